// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath.
//
// Contents:
//   color_t            2-bit colour code
//   GREEN/RED/BLUE/YELLOW  colour constants (0..3)
//   LFSR_MASK          Galois tap mask for the 16-bit right-shift LFSR
//   SEED_DEFAULT       default non-zero LFSR seed
//   lfsr16_next()      one-step LFSR update, shared by every LFSR user
package simon_pkg;

    typedef logic [1:0] color_t;

    localparam color_t GREEN  = 2'd0;
    localparam color_t RED    = 2'd1;
    localparam color_t BLUE   = 2'd2;
    localparam color_t YELLOW = 2'd3;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // Galois right-shift step: the bit shifted out decides whether the
    // tap mask is folded back in. Mask B400 gives the maximal period 2^16-1.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        lfsr16_next = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Galois LFSR.
//
// Loads SEED while reset is high, then advances once per clock with no
// enable. Intended as a generic randomness source: consumers sample the
// current value whenever an event of theirs occurs, so the sampled value
// depends on event timing.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (loads SEED)
//   lfsr   out  current LFSR state (16 bits)
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    assign lfsr_next = lfsr16_next(lfsr_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/simon_seq_store.sv
// Simon pattern store.
//
// Keeps the whole colour pattern in a register array so each round only
// appends one colour. New colours are the low two bits of a free-running
// LFSR at the moment of the append, so player timing selects the pattern.
// A read index walks the pattern for replay and for checking the player.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   clear     in   empty the pattern (len=0, idx=0, overflow=0)
//   append    in   pulse: append lfsr[1:0] to the pattern
//   step      in   pulse: advance idx, saturating at len-1
//   rerun     in   pulse: return idx to 0
//   color     out  colour at idx (0 when empty)
//   idx       out  current read index
//   len       out  number of stored colours, 0..MAX_LEN
//   at_end    out  len!=0 and idx==len-1
//   full      out  len==MAX_LEN
//   overflow  out  sticky: an append arrived while full
//   peek      out  colours idx..idx+3 as {c3,c2,c1,c0}; slots >= len read 0
module simon_seq_store
    import simon_pkg::*;
#(
    parameter int          MAX_LEN = 32,
    parameter int          ADDR_W  = 5,
    parameter logic [15:0] SEED    = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              append,
    input  logic              step,
    input  logic              rerun,
    output logic [1:0]        color,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W:0]   len,
    output logic              at_end,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        peek
);

    localparam int PEEK_N = 4;

    // ------------------------------------------------------------------
    // Randomness source
    // ------------------------------------------------------------------
    logic [15:0] lfsr_value;

    simon_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_value)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    color_t            mem_reg [MAX_LEN];
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              overflow_reg;

    logic              full_int;
    logic              empty_int;
    logic [ADDR_W:0]   last_pos;
    logic [ADDR_W:0]   idx_ext;
    logic              can_step;
    logic              do_write;

    assign full_int  = (len_reg == (ADDR_W+1)'(MAX_LEN));
    assign empty_int = (len_reg == '0);
    // Only meaningful when the pattern is non-empty; every use is guarded.
    assign last_pos  = len_reg - (ADDR_W+1)'(1);
    assign idx_ext   = {1'b0, idx_reg};
    // Uses the pre-append length, so a step coinciding with an append at
    // the last position holds instead of running onto the new colour.
    assign can_step  = !empty_int && (idx_ext < last_pos);
    assign do_write  = append && !full_int && !clear && !reset;

    // Pattern memory: no reset, visibility is controlled by len_reg.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_reg[len_reg[ADDR_W-1:0]] <= lfsr_value[1:0];
        end
    end

    // Length, read index and sticky overflow.
    // Priority: reset > clear > rerun > step; append runs alongside the
    // index control except when clear drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg      <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            len_reg      <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (append) begin
                if (full_int) begin
                    overflow_reg <= 1'b1;
                end else begin
                    len_reg <= len_reg + (ADDR_W+1)'(1);
                end
            end

            if (rerun) begin
                idx_reg <= '0;
            end else if (step && can_step) begin
                idx_reg <= idx_reg + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: look-ahead window starting at idx. Addresses are formed
    // one bit wider than the index so that slots past the end of the
    // array compare as >= len instead of wrapping back to the start.
    // ------------------------------------------------------------------
    color_t peek_slot [PEEK_N];

    genvar gi;
    generate
        for (gi = 0; gi < PEEK_N; gi++) begin : g_peek
            logic [ADDR_W:0] slot_addr;
            assign slot_addr     = idx_ext + (ADDR_W+1)'(gi);
            assign peek_slot[gi] = (slot_addr < len_reg)
                                 ? mem_reg[slot_addr[ADDR_W-1:0]]
                                 : GREEN;
            assign peek[2*gi +: 2] = peek_slot[gi];
        end
    endgenerate

    // idx never exceeds len-1, so slot 0 is valid exactly when non-empty.
    assign color    = peek_slot[0];
    assign idx      = idx_reg;
    assign len      = len_reg;
    assign at_end   = !empty_int && (idx_ext == last_pos);
    assign full     = full_int;
    assign overflow = overflow_reg;

endmodule
